// File: rtl/iddr_deser.sv
// -----------------------------------------------------------------------------
// iddr_deser
//
// Double-data-rate input deserializer. Each channel samples D on both edges
// of C. The bits are grouped into pairs (rising bit first, then falling bit).
// Pairs are assembled into RATIO-bit words, which are presented on Q with a
// one-cycle VALID strobe.
//
// Parameters
//   WIDTH         : number of independent channels (1..32)
//   RATIO         : bits per word per channel (4 or 8)
//   MSB_FIRST     : 0 = first received bit lands in word bit 0,
//                   1 = first received bit lands in word bit RATIO-1
//   IS_C_INVERTED : 1 = the roles of the C rising and falling edges are swapped
//
// Ports
//   C       : in  - single clock; D is sampled on both edges
//   R       : in  - asynchronous active-high reset
//   D       : in  - [WIDTH] DDR serial data, one bit per channel
//   BITSLIP : in  - word-alignment request, sampled on the rising edge
//   Q       : out - [WIDTH*RATIO] words; channel n at Q[n*RATIO +: RATIO]
//   VALID   : out - high for exactly one cycle when Q is updated
//
// Handshake: VALID is a pure strobe with no back-pressure. Q changes only
// on the rising edge that raises VALID. Q holds its value while VALID is low.
//
// Optional feature: define IDDR_DESER_BITSLIP_EN to build the bitslip logic.
// When the macro is undefined, BITSLIP is accepted but ignored. In that case
// the word boundary is fixed from reset.
// -----------------------------------------------------------------------------
module iddr_deser #(
    parameter int WIDTH         = 1,
    parameter int RATIO         = 4,
    parameter bit MSB_FIRST     = 1'b0,
    parameter bit IS_C_INVERTED = 1'b0
) (
    input  logic                   C,
    input  logic                   R,
    input  logic [WIDTH-1:0]       D,
    input  logic                   BITSLIP,
    output logic [WIDTH*RATIO-1:0] Q,
    output logic                   VALID
);

    localparam int         PAIRS    = RATIO / 2;
    localparam logic [1:0] CNT_LAST = 2'(PAIRS - 1);

    if ((RATIO != 4) && (RATIO != 8)) begin : g_bad_ratio
        $error("iddr_deser: RATIO must be 4 or 8");
    end
    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
        $error("iddr_deser: WIDTH must be in 1..32");
    end

    // Local clock whose rising edge is the "rising" role edge.
    logic c_int;
    assign c_int = C ^ IS_C_INVERTED;

    logic [WIDTH-1:0]       dr_q;
    logic [WIDTH-1:0]       df_q;
    logic [1:0]             warm_q;
    logic [1:0]             cnt_q;
    logic [WIDTH*RATIO-1:0] asm_q;
    logic [WIDTH*RATIO-1:0] asm_next;
    logic                   shift_ok;
    logic                   slip_take;
    logic                   shift_en;
    logic                   word_done;

    // Capture flops: rising bit and falling bit of the current pair.
    always_ff @(posedge c_int or posedge R) begin
        if (R) begin
            dr_q <= '0;
        end else begin
            dr_q <= D;
        end
    end

    always_ff @(negedge c_int or posedge R) begin
        if (R) begin
            df_q <= '0;
        end else begin
            df_q <= D;
        end
    end

    // Start-up gate. The first rising edge after reset only captures data.
    // The pair opened on that edge is also discarded, so the first pair
    // shifted is the one whose rising bit was captured on the second edge.
    // This places the first VALID on edge RATIO/2+1, counted from edge 0.
    always_ff @(posedge c_int or posedge R) begin
        if (R) begin
            warm_q <= 2'b00;
        end else begin
            warm_q <= {warm_q[0], 1'b1};
        end
    end

    assign shift_ok = warm_q[1];

`ifdef IDDR_DESER_BITSLIP_EN
    // win_q counts down the rising edges during which a new slip is refused.
    logic [2:0] win_q;

    assign slip_take = shift_ok && BITSLIP && (win_q == 3'd0);

    always_ff @(posedge c_int or posedge R) begin
        if (R) begin
            win_q <= 3'd0;
        end else if (slip_take) begin
            win_q <= 3'(PAIRS);
        end else if (win_q != 3'd0) begin
            win_q <= win_q - 3'd1;
        end
    end
`else
    logic unused_bitslip;
    assign unused_bitslip = BITSLIP;
    assign slip_take      = 1'b0;
`endif

    // A slip drops the pair arriving on this edge and holds the counter.
    // This moves the word boundary by one pair.
    assign shift_en  = shift_ok && !slip_take;
    assign word_done = shift_en && (cnt_q == CNT_LAST);

    // Per-channel assembly. LSB-first shifts pairs in from the top, so the
    // oldest pair ends in bits [1:0] with its rising bit in bit 0.
    // MSB-first shifts in from the bottom, so the oldest rising bit ends
    // in bit RATIO-1.
    always_comb begin
        asm_next = asm_q;
        for (int n = 0; n < WIDTH; n++) begin
            if (MSB_FIRST) begin
                asm_next[n*RATIO +: RATIO] = {asm_q[n*RATIO +: RATIO-2], dr_q[n], df_q[n]};
            end else begin
                asm_next[n*RATIO +: RATIO] = {df_q[n], dr_q[n], asm_q[n*RATIO+2 +: RATIO-2]};
            end
        end
    end

    always_ff @(posedge c_int or posedge R) begin
        if (R) begin
            asm_q <= '0;
            cnt_q <= 2'd0;
            Q     <= '0;
            VALID <= 1'b0;
        end else begin
            VALID <= word_done;
            if (shift_en) begin
                asm_q <= asm_next;
                cnt_q <= word_done ? 2'd0 : cnt_q + 2'd1;
            end
            if (word_done) begin
                Q <= asm_next;
            end
        end
    end

endmodule

// File: tb/tb_iddr_deser.sv
// -----------------------------------------------------------------------------
// tb_iddr_deser
//
// Bench for iddr_deser. It instantiates several configurations that share one
// clock, reset, data and bitslip stimulus:
//   sel 0 : WIDTH=1 RATIO=4 LSB-first
//   sel 1 : WIDTH=1 RATIO=4 MSB-first
//   sel 2 : WIDTH=1 RATIO=8 LSB-first
//   sel 3 : WIDTH=2 RATIO=4 LSB-first
//   sel 4 : WIDTH=1 RATIO=4 LSB-first (slip stimulus phase)
//   sel 5 : WIDTH=1 RATIO=4 LSB-first, IS_C_INVERTED=1 on an inverted clock
//
// Each phase resets every instance and selects one of them. The phase then
// pushes the expected words, each tagged with its rising-edge number, into
// exp_q. Each phase then drives pairs and compares VALID and Q on every edge.
// Edge E0 is the first rising edge after reset is released.
// -----------------------------------------------------------------------------
module tb_iddr_deser;

    // ---------------- clock / reset ----------------
    logic       C = 1'b0;
    logic       c_n;
    logic       R;
    logic [1:0] d;
    logic       bitslip;

    always #5 C = ~C;
    assign c_n = ~C;

    // ---------------- DUTs ----------------
    logic [3:0] qa, qb, qe, qf;
    logic [7:0] qc, qd;
    logic       va, vb, vc, vd, ve, vf;

    iddr_deser #(.WIDTH(1), .RATIO(4), .MSB_FIRST(1'b0), .IS_C_INVERTED(1'b0)) u_a (
        .C(C), .R(R), .D(d[0:0]), .BITSLIP(bitslip), .Q(qa), .VALID(va));
    iddr_deser #(.WIDTH(1), .RATIO(4), .MSB_FIRST(1'b1), .IS_C_INVERTED(1'b0)) u_b (
        .C(C), .R(R), .D(d[0:0]), .BITSLIP(bitslip), .Q(qb), .VALID(vb));
    iddr_deser #(.WIDTH(1), .RATIO(8), .MSB_FIRST(1'b0), .IS_C_INVERTED(1'b0)) u_c (
        .C(C), .R(R), .D(d[0:0]), .BITSLIP(bitslip), .Q(qc), .VALID(vc));
    iddr_deser #(.WIDTH(2), .RATIO(4), .MSB_FIRST(1'b0), .IS_C_INVERTED(1'b0)) u_d (
        .C(C), .R(R), .D(d), .BITSLIP(bitslip), .Q(qd), .VALID(vd));
    iddr_deser #(.WIDTH(1), .RATIO(4), .MSB_FIRST(1'b0), .IS_C_INVERTED(1'b0)) u_e (
        .C(C), .R(R), .D(d[0:0]), .BITSLIP(bitslip), .Q(qe), .VALID(ve));
    iddr_deser #(.WIDTH(1), .RATIO(4), .MSB_FIRST(1'b0), .IS_C_INVERTED(1'b1)) u_f (
        .C(c_n), .R(R), .D(d[0:0]), .BITSLIP(bitslip), .Q(qf), .VALID(vf));

    int         sel;
    logic [7:0] obs_q;
    logic       obs_valid;

    always_comb begin
        obs_q     = 8'h00;
        obs_valid = 1'b0;
        case (sel)
            0: begin obs_q = {4'h0, qa}; obs_valid = va; end
            1: begin obs_q = {4'h0, qb}; obs_valid = vb; end
            2: begin obs_q = qc;         obs_valid = vc; end
            3: begin obs_q = qd;         obs_valid = vd; end
            4: begin obs_q = {4'h0, qe}; obs_valid = ve; end
            5: begin obs_q = {4'h0, qf}; obs_valid = vf; end
            default: begin obs_q = 8'h00; obs_valid = 1'b0; end
        endcase
    end

    // ---------------- scoreboard ----------------
    // Entry layout: {edge number [39:8], expected word [7:0]}.
    logic [39:0] exp_q[$];
    logic [7:0]  hold_q;
    int          edge_n;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input int e, input logic [7:0] q);
        exp_q.push_back({e[31:0], q});
    endtask

    // ---------------- driver tasks ----------------
    // Call this task just after a falling edge. It drives the rising bit and
    // the slip request, checks outputs 1 time unit after the rising edge,
    // then drives the falling bit.
    task automatic pair_step(input logic [1:0] r, input logic [1:0] f, input logic slip);
        logic        exp_v;
        logic [39:0] head;
        d       = r;
        bitslip = slip;
        @(posedge C);
        #1;
        edge_n++;
        exp_v = 1'b0;
        head  = '0;
        if (exp_q.size() > 0) begin
            head  = exp_q[0];
            exp_v = (head[39:8] == edge_n[31:0]);
        end
        chk($sformatf("valid_s%0d_E%0d", sel, edge_n), {31'd0, obs_valid}, {31'd0, exp_v});
        if (exp_v) begin
            chk($sformatf("q_word_s%0d_E%0d", sel, edge_n), {24'd0, obs_q}, {24'd0, head[7:0]});
            hold_q = head[7:0];
            void'(exp_q.pop_front());
        end else begin
            chk($sformatf("q_hold_s%0d_E%0d", sel, edge_n), {24'd0, obs_q}, {24'd0, hold_q});
        end
        d       = f;
        bitslip = 1'b0;
        @(negedge C);
        #1;
    endtask

    // Call this task while C is low. It asserts reset and checks that the
    // previously selected DUT clears at once. It then switches to the new
    // DUT and checks that it is also cleared. It releases reset before the
    // next rising edge, which becomes E0.
    task automatic start_phase(input int s);
        R       = 1'b1;
        d       = 2'b00;
        bitslip = 1'b0;
        #1;
        chk($sformatf("rst_q_prev_s%0d", sel), {24'd0, obs_q}, 32'd0);
        chk($sformatf("rst_valid_prev_s%0d", sel), {31'd0, obs_valid}, 32'd0);
        sel = s;
        #1;
        chk($sformatf("rst_q_s%0d", sel), {24'd0, obs_q}, 32'd0);
        chk($sformatf("rst_valid_s%0d", sel), {31'd0, obs_valid}, 32'd0);
        R      = 1'b0;
        edge_n = -1;
        hold_q = 8'h00;
        exp_q.delete();
    endtask

    task automatic end_phase();
        chk($sformatf("sb_drained_s%0d", sel), exp_q.size(), 32'd0);
    endtask

    // Basic RATIO=4 stream. E0 carries junk that must never appear in Q.
    task automatic run_basic(input int s, input logic [7:0] w0, input logic [7:0] w1);
        start_phase(s);
        exp_push(3, w0);
        exp_push(5, w1);
        pair_step(2'b01, 2'b01, 1'b0);  // E0 junk
        pair_step(2'b01, 2'b00, 1'b0);  // E1 bits 1,0
        pair_step(2'b01, 2'b01, 1'b0);  // E2 bits 1,1
        pair_step(2'b00, 2'b00, 1'b0);  // E3 bits 0,0
        pair_step(2'b00, 2'b01, 1'b0);  // E4 bits 0,1
        pair_step(2'b00, 2'b00, 1'b0);  // E5
        end_phase();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        R       = 1'b1;
        d       = 2'b00;
        bitslip = 1'b0;
        sel     = 0;
        edge_n  = -1;
        hold_q  = 8'h00;
        @(negedge C);
        #1;

        // LSB-first: 1,0,1,1 -> 4'b1101; 0,0,0,1 -> 4'b1000
        run_basic(0, 8'h0D, 8'h08);
        // MSB-first: 1,0,1,1 -> 4'b1011; 0,0,0,1 -> 4'b0001
        run_basic(1, 8'h0B, 8'h01);
        // Inverted-clock instance on an inverted clock behaves like sel 0
        run_basic(5, 8'h0D, 8'h08);

        // RATIO=8: bits of 0x5A LSB-first, then 1,1,0,0,1,1,0,0 -> 0x33
        start_phase(2);
        exp_push(5, 8'h5A);
        exp_push(9, 8'h33);
        pair_step(2'b01, 2'b01, 1'b0);  // E0 junk
        pair_step(2'b00, 2'b01, 1'b0);  // E1
        pair_step(2'b00, 2'b01, 1'b0);  // E2
        pair_step(2'b01, 2'b00, 1'b0);  // E3
        pair_step(2'b01, 2'b00, 1'b0);  // E4
        pair_step(2'b01, 2'b01, 1'b0);  // E5
        pair_step(2'b00, 2'b00, 1'b0);  // E6
        pair_step(2'b01, 2'b01, 1'b0);  // E7
        pair_step(2'b00, 2'b00, 1'b0);  // E8
        pair_step(2'b00, 2'b00, 1'b0);  // E9
        end_phase();

        // WIDTH=2: ch0 alternates 1/0, ch1 constant 1 -> 8'b1111_0101
        start_phase(3);
        exp_push(3, 8'hF5);
        exp_push(5, 8'hF5);
        exp_push(7, 8'hF5);
        for (int k = 0; k < 8; k++) begin
            pair_step(2'b11, 2'b10, 1'b0);
        end
        end_phase();

        // Reset mid-word: one word 1,1,0,1 -> 4'b1011 at E3, then one pair of
        // the next word, then a reset pulse. After release: 0,1,1,1 -> 4'b1110 at E3.
        start_phase(0);
        exp_push(3, 8'h0B);
        pair_step(2'b01, 2'b00, 1'b0);  // E0 junk
        pair_step(2'b01, 2'b01, 1'b0);  // E1
        pair_step(2'b00, 2'b01, 1'b0);  // E2
        pair_step(2'b01, 2'b00, 1'b0);  // E3
        pair_step(2'b00, 2'b00, 1'b0);  // E4: one pair of the next word shifted
        end_phase();
        R = 1'b1;
        #1;
        chk("midword_rst_q", {24'd0, obs_q}, 32'd0);
        chk("midword_rst_valid", {31'd0, obs_valid}, 32'd0);
        #1;
        R      = 1'b0;
        edge_n = -1;
        hold_q = 8'h00;
        exp_push(3, 8'h0E);
        pair_step(2'b01, 2'b01, 1'b0);  // E0 junk
        pair_step(2'b00, 2'b01, 1'b0);  // E1
        pair_step(2'b01, 2'b01, 1'b0);  // E2
        pair_step(2'b00, 2'b00, 1'b0);  // E3
        end_phase();

        // Slip stimulus: pairs alternate (1,1) on odd edges and (0,0) on even
        // edges. BITSLIP is raised on E4 and held over E10..E11.
        start_phase(4);
`ifdef IDDR_DESER_BITSLIP_EN
        exp_push(3,  8'h03);
        exp_push(6,  8'h0C);   // E5 skipped, boundary moved by one pair
        exp_push(8,  8'h0C);
        exp_push(11, 8'h00);   // E10 slip applied on a completing edge; E11 refused
        exp_push(13, 8'h03);   // two accepted slips restore alignment
        exp_push(15, 8'h03);
`else
        for (int e = 3; e <= 15; e += 2) begin
            exp_push(e, 8'h03);
        end
`endif
        for (int k = 0; k < 16; k++) begin
            pair_step((k % 2 == 1) ? 2'b01 : 2'b00,
                      (k % 2 == 1) ? 2'b01 : 2'b00,
                      (k == 4) || (k == 10) || (k == 11));
        end
        end_phase();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
